// File: rtl/barrel_shifter_pkg.sv
// Shared types and rank-partitioning helpers for the pipelined barrel shifter.
// The per-rank payload is data + shamt (width set by the top) plus the shift_ctrl_t sideband.
package barrel_shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_e;

  // Sideband carried with each beat; sign is in_a's MSB captured at input.
  typedef struct packed {
    shift_op_e op;
    logic      sign;
    logic      sticky;
  } shift_ctrl_t;

  localparam int CTRL_W = $bits(shift_ctrl_t);

  function automatic int levels_per_rank(input int levels, input int ranks);
    return (levels + ranks - 1) / ranks;
  endfunction

  function automatic int rank_first(input int r, input int levels, input int ranks);
    return r * levels_per_rank(levels, ranks);
  endfunction

  // Trailing ranks may be left with fewer (or zero) levels.
  function automatic int rank_levels(input int r, input int levels, input int ranks);
    int rem;
    int lpr;
    lpr = levels_per_rank(levels, ranks);
    rem = levels - rank_first(r, levels, ranks);
    if (rem <= 0) return 0;
    return (rem < lpr) ? rem : lpr;
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One pipeline rank: COUNT mux levels starting at level FIRST, then a valid/data slice.
// Optional sticky accumulation under STICKY_EN.
module barrel_shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FIRST = 0,
  parameter int COUNT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      src_valid,
  input  logic [WIDTH-1:0]          src_data,
  input  logic [$clog2(WIDTH)-1:0]  src_shamt,
  input  logic [CTRL_W-1:0]         src_ctrl,
  input  logic                      take,
  output logic                      valid,
  output logic [WIDTH-1:0]          data,
  output logic [$clog2(WIDTH)-1:0]  shamt,
  output logic [CTRL_W-1:0]         ctrl
);

  shift_ctrl_t               src_c;
  shift_ctrl_t               nxt_c;
  logic [COUNT:0][WIDTH-1:0] d_chain;
  logic [COUNT:0]            s_chain;
  logic                      load;

  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d, input int amt,
                                                   input shift_op_e op, input logic sign);
    logic [WIDTH-1:0] ones;
    ones = '1;
    case (op)
      SHIFT_SLL: shift_level = d << amt;
      SHIFT_SRL: shift_level = d >> amt;
      SHIFT_SRA: shift_level = (d >> amt) | (sign ? ~(ones >> amt) : '0);
      default:   shift_level = (d >> amt) | (d << (WIDTH - amt));
    endcase
  endfunction

`ifdef STICKY_EN
  function automatic logic discarded(input logic [WIDTH-1:0] d, input int amt, input shift_op_e op);
    logic [WIDTH-1:0] ones;
    ones = '1;
    discarded = ((op == SHIFT_SRL) || (op == SHIFT_SRA)) && (|(d & ~(ones << amt)));
  endfunction
`endif

  assign src_c      = shift_ctrl_t'(src_ctrl);
  assign d_chain[0] = src_data;
  assign s_chain[0] = src_c.sticky;

  for (genvar g = 0; g < COUNT; g++) begin : g_level
    localparam int AMT = 1 << (FIRST + g);
    assign d_chain[g+1] = src_shamt[FIRST+g] ?
                          shift_level(d_chain[g], AMT, src_c.op, src_c.sign) : d_chain[g];
`ifdef STICKY_EN
    assign s_chain[g+1] = s_chain[g] | (src_shamt[FIRST+g] & discarded(d_chain[g], AMT, src_c.op));
`else
    assign s_chain[g+1] = s_chain[g];
`endif
  end

  assign nxt_c = '{op: src_c.op, sign: src_c.sign, sticky: s_chain[COUNT]};

  // An empty rank always loads; a full one only when its content leaves.
  assign load  = !valid || take;

  // ---- rank register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      shamt <= '0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= src_valid;
      if (src_valid) begin
        data  <= d_chain[COUNT];
        shamt <= src_shamt;
        ctrl  <= nxt_c;
      end
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Registered, back-pressurable SLL/SRL/SRA/ROR shifter split over PIPE_STAGES ranks.
// Define STICKY_EN to generate the shifted-out sticky bit; otherwise out_sticky is 0.
module pipelined_barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_a,
  input  logic [$clog2(WIDTH)-1:0]  in_shamt,
  input  logic [1:0]                in_op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_res,
  output logic                      out_sticky
);

  localparam int L = $clog2(WIDTH);

  // Index 0 is the input port; index r+1 is the register of rank r.
  logic [PIPE_STAGES:0]             vld;
  logic [PIPE_STAGES:0]             rdy;
  logic [PIPE_STAGES:0][WIDTH-1:0]  data;
  logic [PIPE_STAGES:0][L-1:0]      shamt;
  logic [PIPE_STAGES:0][CTRL_W-1:0] ctrl;
  shift_ctrl_t                      in_c;
  shift_ctrl_t                      last_c;
  logic                             unused_bits;

  assign in_c     = '{op: shift_op_e'(in_op), sign: in_a[WIDTH-1], sticky: 1'b0};
  assign vld[0]   = in_valid;
  assign data[0]  = in_a;
  assign shamt[0] = in_shamt;
  assign ctrl[0]  = in_c;

  // Stall chain evaluated in one process, back to front from out_ready.
  always_comb begin
    rdy = '0;
    rdy[PIPE_STAGES] = out_ready;
    for (int r = PIPE_STAGES - 1; r >= 0; r--) begin
      rdy[r] = !vld[r+1] || rdy[r+1];
    end
  end

  assign in_ready = rdy[0];

  for (genvar r = 0; r < PIPE_STAGES; r++) begin : g_rank
    barrel_shift_stage #(
      .WIDTH (WIDTH),
      .FIRST (rank_first(r, L, PIPE_STAGES)),
      .COUNT (rank_levels(r, L, PIPE_STAGES))
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_valid (vld[r]),
      .src_data  (data[r]),
      .src_shamt (shamt[r]),
      .src_ctrl  (ctrl[r]),
      .take      (rdy[r+1]),
      .valid     (vld[r+1]),
      .data      (data[r+1]),
      .shamt     (shamt[r+1]),
      .ctrl      (ctrl[r+1])
    );
  end

  assign last_c    = shift_ctrl_t'(ctrl[PIPE_STAGES]);
  assign out_valid = vld[PIPE_STAGES];
  assign out_res   = data[PIPE_STAGES];

`ifdef STICKY_EN
  assign out_sticky  = last_c.sticky;
  assign unused_bits = ^{shamt[PIPE_STAGES], last_c.op, last_c.sign};
`else
  assign out_sticky  = 1'b0;
  assign unused_bits = ^{shamt[PIPE_STAGES], last_c};
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench: a 2-rank and a 5-rank shifter, expected results queued at acceptance.
module tb_pipelined_barrel_shifter;

  localparam int W  = 32;
  localparam int SW = 5;
`ifdef STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif
  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROR = 2'b11;

  typedef struct {
    logic [W-1:0] res;
    logic         sticky;
    int           stamp;
    int           lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_sticky;
  logic [W-1:0]  in_a = '0, out_res;
  logic [SW-1:0] in_shamt = '0;
  logic [1:0]    in_op = '0;
  logic          v5_in_valid = 1'b0, v5_in_ready, v5_out_valid, v5_out_ready = 1'b1, v5_out_sticky;
  logic [W-1:0]  v5_in_a = '0, v5_out_res;
  logic [SW-1:0] v5_in_shamt = '0;
  logic [1:0]    v5_in_op = '0;

  int   checks = 0, errors = 0, cyc = 0;
  exp_t q2[$], q5[$];
  exp_t e2, e5;
  logic         held = 1'b0, held_sticky = 1'b0;
  logic [W-1:0] held_res = '0;
  int   n5 = 0, first5 = 0, last5 = 0;

  pipelined_barrel_shifter #(.WIDTH(W), .PIPE_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_shamt(in_shamt), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_sticky(out_sticky)
  );

  pipelined_barrel_shifter #(.WIDTH(W), .PIPE_STAGES(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5_in_valid), .in_ready(v5_in_ready), .in_a(v5_in_a),
    .in_shamt(v5_in_shamt), .in_op(v5_in_op), .out_valid(v5_out_valid), .out_ready(v5_out_ready),
    .out_res(v5_out_res), .out_sticky(v5_out_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Bit-by-bit reference; returns {sticky, result}.
  function automatic logic [W:0] model(input logic [W-1:0] a, input int sh, input logic [1:0] op);
    logic [W-1:0] r;
    logic s;
    r = '0;
    s = 1'b0;
    for (int i = 0; i < W; i++) begin
      case (op)
        SLL:     r[i] = (i >= sh) ? a[i-sh] : 1'b0;
        SRL:     r[i] = (i + sh < W) ? a[i+sh] : 1'b0;
        SRA:     r[i] = (i + sh < W) ? a[i+sh] : a[W-1];
        default: r[i] = a[(i+sh)%W];
      endcase
    end
    for (int i = 0; i < sh; i++) if (op == SRL || op == SRA) s = s | a[i];
    return {s & STK, r};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      held <= 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_res", out_res, held_res);
        chk("stall_sticky", 32'(out_sticky), 32'(held_sticky));
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", 32'(q2.size() != 0), 32'd1);
        if (q2.size() != 0) begin
          e2 = q2.pop_front();
          chk("res", out_res, e2.res);
          chk("sticky", 32'(out_sticky), 32'(e2.sticky));
          if (e2.lat >= 0) chk("latency", cyc - e2.stamp, e2.lat);
        end
      end
      held        <= out_valid && !out_ready;
      held_res    <= out_res;
      held_sticky <= out_sticky;
    end
  end

  always @(negedge clk) begin
    if (rst_n && v5_out_valid && v5_out_ready) begin
      chk("p5_beat_expected", 32'(q5.size() != 0), 32'd1);
      if (q5.size() != 0) begin
        e5 = q5.pop_front();
        chk("p5_res", v5_out_res, e5.res);
        chk("p5_sticky", 32'(v5_out_sticky), 32'(e5.sticky));
        chk("p5_latency", cyc - e5.stamp, e5.lat);
        if (n5 == 0) first5 = cyc;
        last5 = cyc;
        n5++;
      end
    end
  end

  task automatic send2(input logic [W-1:0] a, input logic [SW-1:0] sh, input logic [1:0] op,
                       input logic [W-1:0] er, input logic es, input int lat);
    int t;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_shamt = sh; in_op = op;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    q2.push_back('{res: er, sticky: es, stamp: cyc, lat: lat});
  endtask

  task automatic idle2();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain2();
    int t;
    t = 0;
    while (q2.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain2", q2.size(), 0);
  endtask

  initial begin
    logic [W-1:0]  va [10];
    logic [SW-1:0] vs [10];
    logic [1:0]    vo [10];
    logic [W:0]    m;
    int k, idx, t;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_res", out_res, 32'd0);
    chk("rst_out_sticky", 32'(out_sticky), 32'd0);
    chk("rst_p5_out_valid", 32'(v5_out_valid), 32'd0);
    chk("rst_p5_out_res", v5_out_res, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_p5_in_ready", 32'(v5_in_ready), 32'd1);

    // Directed patterns at full throughput.
    out_ready = 1'b1;
    send2(32'h0000_0001, 5'd31, SLL, 32'h8000_0000, 1'b0, 2);
    send2(32'h8000_0000, 5'd4,  SRA, 32'hF800_0000, 1'b0, 2);
    send2(32'h8000_0000, 5'd4,  SRL, 32'h0800_0000, 1'b0, 2);
    send2(32'h1234_5678, 5'd8,  ROR, 32'h7812_3456, 1'b0, 2);
    send2(32'h0000_00FF, 5'd4,  SRL, 32'h0000_000F, STK,  2);
    send2(32'h0000_00F0, 5'd4,  SRL, 32'h0000_000F, 1'b0, 2);
    send2(32'hFFFF_FFFF, 5'd4,  SLL, 32'hFFFF_FFF0, 1'b0, 2);
    send2(32'hFFFF_FFFF, 5'd31, SRA, 32'hFFFF_FFFF, STK,  2);
    send2(32'hA5A5_A5A5, 5'd0,  ROR, 32'hA5A5_A5A5, 1'b0, 2);
    send2(32'h0000_0003, 5'd1,  ROR, 32'h8000_0001, 1'b0, 2);
    idle2();
    drain2();

    // Backpressure: 10 back-to-back beats, out_ready low for cycles 3..6.
    for (int i = 0; i < 10; i++) begin
      va[i] = $urandom;
      vs[i] = SW'($urandom_range(31, 0));
      vo[i] = 2'($urandom_range(3, 0));
    end
    k = 0;
    idx = 0;
    while (idx < 10 && k < 100) begin
      @(posedge clk); #1;
      out_ready = !(k >= 3 && k <= 6);
      in_valid = 1'b1; in_a = va[idx]; in_shamt = vs[idx]; in_op = vo[idx];
      @(negedge clk);
      if (k == 3) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      if (k == 7) chk("bp_in_ready_high", 32'(in_ready), 32'd1);
      if (in_ready) begin
        m = model(va[idx], int'(vs[idx]), vo[idx]);
        q2.push_back('{res: m[W-1:0], sticky: m[W], stamp: cyc, lat: -1});
        idx++;
      end
      k++;
    end
    chk("bp_all_sent", idx, 10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain2();

    // Reset with two beats in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send2(32'h1111_1111, 5'd3, SLL, 32'h8888_8888, 1'b0, -1);
    send2(32'h0F0F_0F0F, 5'd4, ROR, 32'hF0F0_F0F0, 1'b0, -1);
    idle2();
    chk("flight_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    q2.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_stale_beat", 32'(out_valid), 32'd0);
    end
    send2(32'h0000_0100, 5'd8, SRL, 32'h0000_0001, 1'b0, 2);
    idle2();
    drain2();

    // Five-rank instance: 100 random beats, continuous out_ready.
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      v5_in_valid = 1'b1;
      v5_in_a = $urandom;
      v5_in_shamt = SW'($urandom_range(31, 0));
      v5_in_op = 2'($urandom_range(3, 0));
      @(negedge clk);
      chk("p5_in_ready", 32'(v5_in_ready), 32'd1);
      if (v5_in_ready) begin
        m = model(v5_in_a, int'(v5_in_shamt), v5_in_op);
        q5.push_back('{res: m[W-1:0], sticky: m[W], stamp: cyc, lat: 5});
      end
    end
    @(posedge clk); #1;
    v5_in_valid = 1'b0;
    t = 0;
    while (q5.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("p5_drain", q5.size(), 0);
    chk("p5_count", n5, 100);
    chk("p5_throughput", last5 - first5, 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
